// File: rtl/pwm_adc_seq_pkg.sv
// rtl/pwm_adc_seq_pkg.sv - shared types and default sizes for the PWM-ramp ADC sequencer
// Purpose: conversion state enum and default parameter values used by pwm_adc_seq.
// Ports: none (package).
package pwm_adc_seq_pkg;

    localparam int DEF_NBITS = 6;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISCHARGE = 2'd1,
        ST_RAMP      = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_adc_seq_cmp_sync.sv
// rtl/pwm_adc_seq_cmp_sync.sv - two-flop synchronizer for the LVDS comparator
// Purpose: brings the asynchronous comparator level into the clk_i domain.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, both flops clear to 0
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i edges behind d_i
module cmp_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pwm_adc_seq.sv
// rtl/pwm_adc_seq.sv - conversion sequencer for the PWM-ramp single-slope ADC
// Purpose: clears the pwm_ramp counter for a settle time, enables the ramp,
//   captures the duty cycle when the synchronized comparator trips (all-ones
//   plus overflow on timeout) and offers the result over valid/ready.
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   start_i, cont_i, abort_i - start pulse, continuous mode, abort to IDLE
//   settle_i, timeout_i     - DISCHARGE length (settle_i+1 cycles), RAMP limit
//   cmp_i                   - asynchronous comparator (filtered PWM > input)
//   dc_i                    - current pwm_ramp duty cycle
//   pwm_clear_o, pwm_enable_o - controls to pwm_ramp
//   busy_o                  - not IDLE
//   result_o, ovf_o         - converted value and timeout flag
//   valid_o, ready_i        - result handshake
// Option: PWM_ADC_SEQ_AVG_EN - each result averages 2**AVG_LOG2 passes.
module pwm_adc_seq
    import pwm_adc_seq_pkg::*;
#(
    parameter int NBITS    = DEF_NBITS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] settle_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             cmp_i,
    input  logic [NBITS-1:0] dc_i,
    output logic             pwm_clear_o,
    output logic             pwm_enable_o,
    output logic             busy_o,
    output logic [NBITS-1:0] result_o,
    output logic             ovf_o,
    output logic             valid_o,
    input  logic             ready_i
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NBITS-1:0] result_q, result_d, pass_val;
    logic             ovf_q, ovf_d, pass_ovf, start_conv, cmp_s;

    cmp_sync u_cmp_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cmp_i),
        .q_o    (cmp_s)
    );

    // Settle/timeout counter saturates instead of wrapping.
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // A crossing beats a simultaneous timeout, so the value depends only on cmp_s.
    assign pass_val = cmp_s ? dc_i : '1;
    assign pass_ovf = ~cmp_s;

`ifdef PWM_ADC_SEQ_AVG_EN
    logic [AVG_LOG2-1:0]       pass_q, pass_d;
    logic [NBITS+AVG_LOG2-1:0] acc_q, acc_d, acc_sum;
    logic                      acc_ovf_q, acc_ovf_d;

    assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, pass_val};
`else
    // AVG_LOG2 only matters for the averaging build.
    logic unused_avg_log2;
    assign unused_avg_log2 = (AVG_LOG2 != 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
`ifdef PWM_ADC_SEQ_AVG_EN
            pass_q    <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
`ifdef PWM_ADC_SEQ_AVG_EN
            pass_q    <= pass_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        result_d   = result_q;
        ovf_d      = ovf_q;
        start_conv = 1'b0;
`ifdef PWM_ADC_SEQ_AVG_EN
        pass_d     = pass_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_DISCHARGE;
                    start_conv = 1'b1;
                end
            end
            ST_DISCHARGE: begin
                if (cnt_q == settle_i) begin
                    state_d = ST_RAMP;
                    cnt_d   = '0;
                end
            end
            ST_RAMP: begin
                if (cmp_s || (cnt_q == timeout_i)) begin
`ifdef PWM_ADC_SEQ_AVG_EN
                    acc_d     = acc_sum;
                    acc_ovf_d = acc_ovf_q | pass_ovf;
                    pass_d    = pass_q + AVG_LOG2'(1);
                    if (&pass_q) begin
                        result_d = acc_sum[NBITS+AVG_LOG2-1:AVG_LOG2];
                        ovf_d    = acc_ovf_q | pass_ovf;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_DISCHARGE;
                        cnt_d   = '0;
                    end
`else
                    result_d = pass_val;
                    ovf_d    = pass_ovf;
                    state_d  = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    if (cont_i) begin
                        state_d    = ST_DISCHARGE;
                        start_conv = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (start_conv) begin
            cnt_d = '0;
`ifdef PWM_ADC_SEQ_AVG_EN
            pass_d    = '0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
`endif
        end

        // Abort overrides everything; the published result is left untouched.
        if (abort_i) begin
            state_d = ST_IDLE;
`ifdef PWM_ADC_SEQ_AVG_EN
            pass_d    = '0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
`endif
        end
    end

    assign pwm_clear_o  = (state_q != ST_RAMP);
    assign pwm_enable_o = (state_q == ST_RAMP);
    assign busy_o       = (state_q != ST_IDLE);
    assign valid_o      = (state_q == ST_DONE);
    assign result_o     = result_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_pwm_adc_seq.sv
// tb/tb_pwm_adc_seq.sv - self-checking bench for pwm_adc_seq
module tb_pwm_adc_seq;

    localparam int NBITS    = 6;
    localparam int CNT_W    = 16;
    localparam int AVG_LOG2 = 2;
    localparam int MAXC     = 4096;
`ifdef PWM_ADC_SEQ_AVG_EN
    localparam int PASSES = 1 << AVG_LOG2;
`else
    localparam int PASSES = 1;
`endif
    localparam int P_IDLE = 0;
    localparam int P_DIS  = 1;
    localparam int P_RAMP = 2;
    localparam int P_DONE = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, cont = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [CNT_W-1:0] settle = '0, timeout = '0;
    logic             cmp;
    logic [NBITS-1:0] dc;
    logic             pwm_clear, pwm_enable, busy, ovf, valid;
    logic [NBITS-1:0] result;

    pwm_adc_seq #(.NBITS(NBITS), .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .cont_i       (cont),
        .abort_i      (abort),
        .settle_i     (settle),
        .timeout_i    (timeout),
        .cmp_i        (cmp),
        .dc_i         (dc),
        .pwm_clear_o  (pwm_clear),
        .pwm_enable_o (pwm_enable),
        .busy_o       (busy),
        .result_o     (result),
        .ovf_o        (ovf),
        .valid_o      (valid),
        .ready_i      (ready)
    );

    always #5 clk = ~clk;

    // cycle c is the interval after posedge number c
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pwm_ramp stand-in: duty counter cleared by clear, counts while enabled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               dc <= '0;
        else if (pwm_clear)                       dc <= '0;
        else if (pwm_enable && (dc != 6'd63))     dc <= dc + 6'd1;
    end

    // comparator threshold may step by th_step on every ramp pass of a conversion
    int th_base = 0, th_step = 0, ramp_idx = 0, ramp_base = 0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (pwm_enable && !prev_en) ramp_idx = ramp_idx + 1;
        prev_en = pwm_enable;
    end
    assign cmp = (int'(dc) >= th_base + th_step * (ramp_idx - ramp_base - 1));

    int n_checks = 0, n_err = 0;
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected timeline, one entry per cycle
    int               e_ph [MAXC];
    logic [NBITS-1:0] e_res[MAXC];
    logic             e_ovf[MAXC];

    task automatic fill(input int from, input int to, input int ph);
        for (int c = from; c <= to && c < MAXC; c++) e_ph[c] = ph;
    endtask

    task automatic fill_res(input int from, input int res, input int o);
        for (int c = from; c < MAXC; c++) begin
            e_res[c] = NBITS'(res);
            e_ovf[c] = o[0];
        end
    endtask

    // Conversions started by start sampled at edge n; first DISCHARGE cycle is n.
    task automatic plan(input int n, input int st, input int to, input int thb, input int ths,
                        input int rdelay, input int nconv, output int d_first, output int d_last);
        int d, sum, o, th, jc, jf, val, rd;
        d = n;
        d_first = 0;
        d_last  = 0;
        for (int k = 0; k < nconv; k++) begin
            sum = 0;
            o   = 0;
            for (int p = 0; p < PASSES; p++) begin
                th = thb + ths * p;
                fill(d, d + st, P_DIS);
                // comparator goes high on ramp cycle th, seen two cycles later
                jc = (th == 0) ? 0 : th + 2;
                if (jc <= to) begin
                    jf  = jc;
                    val = (jc > 63) ? 63 : jc;
                end else begin
                    jf  = to;
                    val = 63;
                    o   = 1;
                end
                fill(d + st + 1, d + st + 1 + jf, P_RAMP);
                sum += val;
                d = d + st + 2 + jf;
            end
            rd = (k == 0) ? rdelay : 0;
            fill(d, d + rd, P_DONE);
            fill_res(d, sum / PASSES, o);
            if (k == 0) d_first = d;
            d_last = d;
            d = d + rd + 1;
        end
        fill(d, MAXC - 1, P_IDLE);
    endtask

    task automatic model_abort(input int a);
        fill(a, MAXC - 1, P_IDLE);
        fill_res(a, int'(e_res[a-1]), int'(e_ovf[a-1]));
    endtask

    int valid_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && cyc < MAXC) begin
            check($sformatf("pwm_clear@%0d", cyc), pwm_clear, e_ph[cyc] != P_RAMP);
            check($sformatf("pwm_enable@%0d", cyc), pwm_enable, e_ph[cyc] == P_RAMP);
            check($sformatf("busy@%0d", cyc), busy, e_ph[cyc] != P_IDLE);
            check($sformatf("valid@%0d", cyc), valid, e_ph[cyc] == P_DONE);
            check($sformatf("result@%0d", cyc), result, e_res[cyc]);
            check($sformatf("ovf@%0d", cyc), ovf, e_ovf[cyc]);
            if (valid) valid_cnt++;
        end
    end

    task automatic wait_cyc(input int c);
        if (c >= MAXC) begin
            check("cycle_budget", c, MAXC - 1);
            return;
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic go(input int st, input int to, input int thb, input int ths, input int rdelay,
                      input int nconv, output int n, output int d_first, output int d_last);
        @(negedge clk);
        settle    = CNT_W'(st);
        timeout   = CNT_W'(to);
        th_base   = thb;
        th_step   = ths;
        ramp_base = ramp_idx;
        start     = 1'b1;
        n = cyc + 1;
        plan(n, st, to, thb, ths, rdelay, nconv, d_first, d_last);
        @(negedge clk);
        start = 1'b0;
    endtask

    // single conversion with literal expected result/ovf and one valid cycle
    task automatic one(input string name, input int st, input int to, input int thb, input int ths,
                       input int exp_res, input int exp_ovf);
        int n, df, dl, v0;
        v0 = valid_cnt;
        go(st, to, thb, ths, 0, 1, n, df, dl);
        wait_cyc(dl + 3);
        check({name, "_result"}, result, exp_res);
        check({name, "_ovf"}, ovf, exp_ovf);
        check({name, "_valid_cycles"}, valid_cnt - v0, 1);
    endtask

    int n, df, dl;

    initial begin
        fill(0, MAXC - 1, P_IDLE);
        fill_res(0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_clear", pwm_clear, 1);
        check("rst_enable", pwm_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        one("basic", 10, 1000, 20, 0, 22, 0);
        one("overflow", 10, 50, 64, 0, 63, 1);
        one("cmp_high", 4, 1000, 0, 0, 0, 0);
        one("tie_cross_wins", 10, 22, 20, 0, 22, 0);
        one("timeout_first", 10, 21, 20, 0, 63, 1);
        one("settle_zero", 0, 5, 64, 0, 63, 1);
        one("basic2", 10, 1000, 20, 0, 22, 0);

        // backpressure in continuous mode, then a second automatic conversion
        @(negedge clk);
        cont  = 1'b1;
        ready = 1'b0;
        go(10, 1000, 20, 0, 20, 2, n, df, dl);
        wait_cyc(df + 10);
        check("bp_valid_held", valid, 1);
        check("bp_result_held", result, 22);
        wait_cyc(df + 20);
        ready = 1'b1;
        wait_cyc(df + 21);
        check("bp_valid_cleared", valid, 0);
        check("bp_restart_busy", busy, 1);
        wait_cyc(df + 22);
        cont = 1'b0;
        wait_cyc(dl + 3);
        check("bp_second_result", result, 22);

        // abort mid-RAMP, then a normal conversion
        go(5, 1000, 30, 0, 0, 1, n, df, dl);
        wait_cyc(n + 11);
        abort = 1'b1;
        model_abort(cyc + 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_clear", pwm_clear, 1);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result_kept", result, 22);
        repeat (3) @(negedge clk);
        one("after_abort", 10, 1000, 15, 0, 17, 0);

        // asynchronous reset mid-RAMP
        go(5, 1000, 30, 0, 0, 1, n, df, dl);
        wait_cyc(n + 9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_clear", pwm_clear, 1);
        check("arst_enable", pwm_enable, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_result", result, 0);
        check("arst_ovf", ovf, 0);
        fill(cyc, MAXC - 1, P_IDLE);
        fill_res(cyc, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        one("after_reset", 10, 1000, 20, 0, 22, 0);

`ifdef PWM_ADC_SEQ_AVG_EN
        // captures 10, 11, 12, 13 -> 46 / 4 = 11
        one("average", 10, 1000, 8, 1, 11, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
